// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial N-bit adder. A single full-adder bit cell (sum = a^b^c,
// carry = majority) is reused once per clock. The carry between bit
// positions is held in a register. Two operands and a carry-in are loaded on
// the edge that accepts start. Bits are then processed LSB first, one per
// clock, for N clocks. The assembled sum and carry-out are registered on the
// final bit edge.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  begin an addition (accepted in IDLE or DONE)
//   a      in   N  operand A, sampled on the accepting edge only
//   b      in   N  operand B, sampled on the accepting edge only
//   ci     in   1  carry-in, sampled on the accepting edge only
//   busy   out  1  addition in progress
//   done   out  1  one-cycle pulse, s/co hold a fresh result
//   s      out  N  registered sum (holds until the next final bit edge)
//   co     out  1  registered carry-out
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  sa, sb, ps;
  logic          c;
  logic [CW-1:0] cnt;

  logic bit_sum, bit_carry, last_bit, accept;

  // The one full-adder cell, fed by the LSBs of the operand shifters and the
  // stored carry.
  assign bit_sum   = sa[0] ^ sb[0] ^ c;
  assign bit_carry = (sa[0] & sb[0]) | (sb[0] & c) | (sa[0] & c);

  // cnt counts completed RUN edges. The edge that sees N-1 processes the MSB.
  assign last_bit = (cnt == CW'(N - 1));

  // A new operation can start both from IDLE and from DONE. Accepting in DONE
  // gives back-to-back operation without an idle bubble.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register, including the result, is reset. An
  // aborted operation must leave s/co at zero, not at stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      ps  <= '0;
      c   <= 1'b0;
      cnt <= '0;
      s   <= '0;
      co  <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      c   <= ci;
      ps  <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= {1'b0, sa[N-1:1]};
      sb  <= {1'b0, sb[N-1:1]};
      c   <= bit_carry;
      ps  <= {bit_sum, ps[N-1:1]};
      cnt <= cnt + CW'(1);
      // On the MSB edge, publish the result directly from the bit cell.
      // ps is one bit short at this point.
      if (last_bit) begin
        s  <= {bit_sum, ps[N-1:1]};
        co <= bit_carry;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder with N = 8. A cycle-level reference
// model predicts busy, done, s and co from the adder's contract:
//   - an accepted operation is busy for N cycles;
//   - it then shows done for one cycle, with {co,s} = a+b+ci.
// A compare process checks the DUT against the model on every falling edge.
// Directed scenarios add hand-computed literal expectations on top.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic         ci;
  logic         busy, done;
  logic [N-1:0] s;
  logic         co;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model.
  // m_phase 0 means idle. Values 1..N are the busy cycles after acceptance.
  // N+1 is the single result cycle.
  int           m_phase;
  logic [N:0]   m_pend;
  logic [N-1:0] m_s;
  logic         m_co;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_pend  <= '0;
      m_s     <= '0;
      m_co    <= 1'b0;
    end else if ((m_phase == 0 || m_phase == N + 1) && start) begin
      m_phase <= 1;
      m_pend  <= {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    end else if (m_phase == N + 1) begin
      m_phase <= 0;
    end else if (m_phase == N) begin
      m_phase     <= N + 1;
      {m_co, m_s} <= m_pend;
    end else if (m_phase != 0) begin
      m_phase <= m_phase + 1;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= N));
    check("done", 32'(done), 32'(m_phase == N + 1));
    check("s", 32'(s), 32'(m_s));
    check("co", 32'(co), 32'(m_co));
    check("done_while_busy", 32'(done & busy), 32'd0);
  end

  // Called at the falling edge right after the accepting edge. Steps falling
  // edges until done. Returns the edge count and the number of busy cycles.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_op, input logic tci,
                        input logic [N-1:0] es, input logic eco, input string tag);
    int cyc, bcnt;
    @(negedge clk);
    a = ta; b = tb_op; ci = tci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, 32'(cyc), 32'(N));
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_co"}, 32'(co), 32'(eco));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bcnt, gap;
    logic [N-1:0] ra, rb;
    logic         rci;
    logic [N:0]   rsum;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    rst_n = 1'b1;

    // Basic operation, including an explicit busy-duration check.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("t1_busy_cycles", 32'(bcnt), 32'd8);
    check("t1_latency", 32'(cyc), 32'd8);
    check("t1_s", 32'(s), 32'h10);
    check("t1_co", 32'(co), 32'd0);

    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");
    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "t2c");

    // Operands change during RUN with start held high. The DONE-cycle start
    // then launches AA+55.
    @(negedge clk);
    a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hAA; b = 8'h55;
    wait_done(cyc, bcnt);
    check("t3a_latency", 32'(cyc), 32'd8);
    check("t3a_s", 32'(s), 32'h46);
    check("t3a_co", 32'(co), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("t3_single_done", 32'(done), 32'd0);
    wait_done(cyc, bcnt);
    check("t3b_latency", 32'(cyc), 32'd8);
    check("t3b_s", 32'(s), 32'hFF);
    check("t3b_co", 32'(co), 32'd0);

    // Back-to-back with start held continuously.
    @(negedge clk);
    a = 8'h80; b = 8'h80; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    wait_done(cyc, bcnt);
    check("t4a_s", 32'(s), 32'h00);
    check("t4a_co", 32'(co), 32'd1);
    @(negedge clk);
    gap = 1;
    while (!done && gap < 40) begin
      check("t4_hold_s", 32'(s), 32'h00);
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    check("t4_done_spacing", 32'(gap), 32'd9);
    check("t4b_s", 32'(s), 32'h03);
    check("t4b_co", 32'(co), 32'd0);

    // Reset at E4 of an operation.
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_s", 32'(s), 32'd0);
    check("t5_co", 32'(co), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t5_no_done", 32'(done), 32'd0);
    end
    run_op(8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, "t5_after");

    // Random sweep.
    for (int i = 0; i < 1000; i++) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      rci  = 1'($urandom);
      rsum = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rci};
      gap  = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      run_op(ra, rb, rci, rsum[N-1:0], rsum[N], "rand");
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
